dmem_bus_responder: RTL



---
 rtl/dmem_bus_pkg.sv | 27 ++
 rtl/dmem_word_array.sv | 34 +++
 rtl/dmem_bus_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dmem_bus_pkg.sv
// Shared types and helpers for the data-memory bus responder.
// The fault check compares in one extra bit so the end of the window cannot wrap.
package dmem_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic addr_fault(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W:0]   span);
      logic [ADDR_W:0] a;
      logic [ADDR_W:0] lo;
      logic [ADDR_W:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + span;
      return (addr[1:0] != 2'b00) || (a < lo) || (a >= hi);
   endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word array with byte-lane writes and a registered read port; storage is not reset.
module dmem_word_array
   import dmem_bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_q;

   // Byte-enabled write and read-before-write registered read
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be_i[i]) begin
               mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_bus_responder.sv
// Single-outstanding load/store responder with programmable wait states.
// Stores commit on the acceptance edge; loads return the word read on the edge entering RESP.
module dmem_bus_responder
   import dmem_bus_pkg::*;
#(
   parameter int              DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int              LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int              AW     = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] SPAN   = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]      LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic              fault_q;
   logic [AW-1:0]     idx_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;

   logic              accept_s;
   logic              fault_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] off_s;
   logic [AW-1:0]     req_idx_s;
   logic [AW-1:0]     rd_idx_s;
   logic [DATA_W-1:0] arr_rdata_s;
   logic              unused_off_s;

   assign accept_s     = req_valid & req_ready_q;
   assign fault_s      = addr_fault(req_addr, BASE_ADDR, SPAN);
   assign off_s        = req_addr - BASE_ADDR;
   assign req_idx_s    = off_s[AW+1:2];
   assign unused_off_s = ^{off_s[ADDR_W-1:AW+2], off_s[1:0]};
   assign wr_en_s      = accept_s & req_we & ~fault_s;
   // The read port tracks the incoming address in IDLE so a zero-wait load still sees its word
   assign rd_idx_s     = (state_q == IDLE) ? req_idx_s : idx_q;

   dmem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk_i   (clk),
      .we_i    (wr_en_s),
      .be_i    (req_be),
      .waddr_i (req_idx_s),
      .wdata_i (req_wdata),
      .raddr_i (rd_idx_s),
      .rdata_o (arr_rdata_s)
   );

   // Request/wait/response sequencing with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         fault_q     <= 1'b0;
         idx_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  we_q        <= req_we;
                  fault_q     <= fault_s;
                  idx_q       <= req_idx_s;
                  req_ready_q <= 1'b0;
                  if (LATENCY == 0) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= fault_s;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= LAT_M1;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= fault_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
            end
         endcase
      end
   end

   // Array read data is stable in RESP since the read index is held and no write can occur
   assign rsp_rdata = (rsp_valid_q & ~we_q & ~fault_q) ? arr_rdata_s : {DATA_W{1'b0}};
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;

endmodule
